// File: rtl/addsub_pkg.sv
// addsub_pkg
//   Shared definitions for the add/sub command sequencer: datapath width,
//   the packed command record buffered in the FIFO, and the FSM states.
package addsub_pkg;

   localparam int unsigned DATA_W = 8;

   // One buffered command: {sel, src1, src2} = 1 + 2*DATA_W bits.
   typedef struct packed {
      logic              sel;
      logic [DATA_W-1:0] src1;
      logic [DATA_W-1:0] src2;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/addsub_cmd_fifo.sv
// addsub_cmd_fifo
//   Command buffer, DEPTH entries of cmd_t. Wrapping read/write pointers plus
//   an occupancy count. Pushes while full and pops while empty are ignored.
// Ports
//   clk, n_rst     clock, asynchronous active-low reset
//   push/push_data write request and command record
//   pop/pop_data   read request and head-of-queue record (valid when !empty)
//   full, empty    occupancy flags
module addsub_cmd_fifo
   import addsub_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic push,
   input  cmd_t push_data,
   input  logic pop,
   output cmd_t pop_data,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/addsub_cmd_seq.sv
// addsub_cmd_seq
//   Sequencer in front of the 8-bit add/sub unit. Buffers commands, issues
//   one at a time (start pulse, operands held until done), captures the
//   result and presents it on a valid/ready response port. A missing done
//   within TIMEOUT wait cycles drops the command and sets err_timeout.
// Ports
//   cmd_valid/cmd_ready/cmd_sel/cmd_src1/cmd_src2  command input (valid/ready)
//   rsp_valid/rsp_ready/rsp_result/rsp_sel         response output (valid/ready)
//   alu_start/alu_sel/alu_src1/alu_src2            drive to add/sub unit
//   alu_result/alu_done                            return from add/sub unit
//   busy         FSM active or commands buffered
//   err_timeout  sticky wait-timeout flag (cleared by reset only)
//   op_count     completed response handshakes, wraps
module addsub_cmd_seq
   import addsub_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_sel,
   input  logic [DATA_W-1:0] cmd_src1,
   input  logic [DATA_W-1:0] cmd_src2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_sel,
   output logic              alu_start,
   output logic              alu_sel,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_done,
   output logic              busy,
   output logic              err_timeout,
   output logic [7:0]        op_count
);

   localparam int unsigned    TW      = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

   state_t        state;
   state_t        state_n;
   cmd_t          push_cmd;
   cmd_t          head_cmd;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          capture;
   logic          timeout_hit;
   logic [TW-1:0] wait_cnt;

   assign push_cmd  = '{sel: cmd_sel, src1: cmd_src1, src2: cmd_src2};
   assign cmd_ready = ~fifo_full;
   assign busy      = (state != IDLE) | ~fifo_empty;

   addsub_cmd_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (cmd_valid),
      .push_data (push_cmd),
      .pop       (pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n     = state;
      pop         = 1'b0;
      alu_start   = 1'b0;
      rsp_valid   = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            alu_start = 1'b1;
            state_n   = WAIT;
         end
         WAIT: begin
            if (alu_done) begin
               capture = 1'b1;
               state_n = RESP;
            end else if (wait_cnt == TO_LAST) begin
               // This is the TIMEOUT-th cycle spent waiting: drop the command.
               timeout_hit = 1'b1;
               state_n     = IDLE;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Operands only load on a pop, which happens only in IDLE, so they stay
   // stable through ISSUE and WAIT for the combinational unit.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         alu_sel     <= 1'b0;
         alu_src1    <= '0;
         alu_src2    <= '0;
         rsp_sel     <= 1'b0;
         rsp_result  <= '0;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
         op_count    <= '0;
      end else begin
         if (pop) begin
            alu_sel  <= head_cmd.sel;
            alu_src1 <= head_cmd.src1;
            alu_src2 <= head_cmd.src2;
         end
         if (state == ISSUE)                wait_cnt <= '0;
         else if (state == WAIT && !alu_done) wait_cnt <= wait_cnt + 1'b1;
         if (capture) begin
            rsp_result <= alu_result;
            rsp_sel    <= alu_sel;
         end
         if (timeout_hit)           err_timeout <= 1'b1;
         if (rsp_valid && rsp_ready) op_count   <= op_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_addsub_cmd_seq.sv
// tb_addsub_cmd_seq
//   Self-checking bench for addsub_cmd_seq. A behavioural add/sub unit
//   (done one cycle after start, combinational result) sits beside the DUT;
//   expected results come from plain integer arithmetic on the commands sent.
module tb_addsub_cmd_seq;

   localparam int TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_sel = 1'b0;
   logic [7:0] cmd_src1 = '0;
   logic [7:0] cmd_src2 = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_result;
   logic       rsp_sel;
   logic       alu_start;
   logic       alu_sel;
   logic [7:0] alu_src1;
   logic [7:0] alu_src2;
   logic [7:0] alu_result;
   logic       alu_done;
   logic       busy;
   logic       err_timeout;
   logic [7:0] op_count;

   int checks = 0;
   int errors = 0;
   int exp_ops = 0;

   bit         hang = 1'b0;
   logic       done_q;
   logic [8:0] got_q [$];
   int         start_cnt = 0;

   addsub_cmd_seq #(
      .DEPTH   (4),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_sel     (cmd_sel),
      .cmd_src1    (cmd_src1),
      .cmd_src2    (cmd_src2),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_sel     (rsp_sel),
      .alu_start   (alu_start),
      .alu_sel     (alu_sel),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_result  (alu_result),
      .alu_done    (alu_done),
      .busy        (busy),
      .err_timeout (err_timeout),
      .op_count    (op_count)
   );

   always #5 clk = ~clk;

   // Behavioural add/sub unit; hang suppresses done.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) done_q <= 1'b0;
      else        done_q <= alu_start & ~hang;
   end
   assign alu_done   = done_q;
   assign alu_result = alu_sel ? 8'(alu_src1 - alu_src2) : 8'(alu_src1 + alu_src2);

   // Record every response handshake and every start pulse.
   always @(posedge clk) begin
      if (n_rst && rsp_valid && rsp_ready) got_q.push_back({rsp_sel, rsp_result});
      if (alu_start) start_cnt <= start_cnt + 1;
   end

   function automatic logic [7:0] ref_op(input bit s, input logic [7:0] a, input logic [7:0] b);
      int t;
      t = s ? (int'(a) - int'(b) + 256) : (int'(a) + int'(b));
      return 8'(t % 256);
   endfunction

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Holds the command until accepted; reports acceptance and any stall.
   task automatic send(input bit s, input logic [7:0] a, input logic [7:0] b,
                       output bit ok, output bit stalled);
      int  g;
      bit  acc;
      g = 0; ok = 1'b0; stalled = 1'b0;
      cmd_valid = 1'b1; cmd_sel = s; cmd_src1 = a; cmd_src2 = b;
      while (!ok && g < 100) begin
         acc = cmd_ready;
         if (!acc) stalled = 1'b1;
         tick;
         ok = acc;
         g++;
      end
   endtask

   task automatic wait_rsp(input int n, output bit ok);
      int g;
      g = 0;
      while (got_q.size() < n && g < 300) begin
         tick;
         g++;
      end
      ok = (got_q.size() >= n);
   endtask

   task automatic test_reset;
      n_rst = 1'b0;
      #3;
      checks++;
      if ({cmd_ready, rsp_valid, alu_start, busy, err_timeout, rsp_sel, alu_sel} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 1000000",
                  {cmd_ready, rsp_valid, alu_start, busy, err_timeout, rsp_sel, alu_sel});
      end
      checks++;
      if ({op_count, rsp_result, alu_src1, alu_src2} !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs: got %h expected 00000000",
                  {op_count, rsp_result, alu_src1, alu_src2});
      end
      tick; tick;
      n_rst = 1'b1;
      tick;
      exp_ops = 0;
   endtask

   task automatic test_single_add;
      bit ok, st;
      logic [7:0] e;
      rsp_ready = 1'b1;
      got_q.delete();
      e = ref_op(1'b0, 8'h25, 8'h13);
      send(1'b0, 8'h25, 8'h13, ok, st);   // handshake = cycle 0
      cmd_valid = 1'b0;
      checks++;
      if (!ok || alu_start !== 1'b0) begin
         errors++;
         $display("FAIL add_cycle1: accepted=%0b alu_start=%b expected 1/0", ok, alu_start);
      end
      tick;                                 // cycle 2
      checks++;
      if ({alu_start, alu_sel, alu_src1, alu_src2} !== {1'b1, 1'b0, 8'h25, 8'h13}) begin
         errors++;
         $display("FAIL add_issue: got start=%b sel=%b a=%h b=%h expected 1 0 25 13",
                  alu_start, alu_sel, alu_src1, alu_src2);
      end
      tick;                                 // cycle 3
      checks++;
      if ({alu_start, rsp_valid, alu_src1, alu_src2} !== {1'b0, 1'b0, 8'h25, 8'h13}) begin
         errors++;
         $display("FAIL add_wait: got start=%b rsp_valid=%b a=%h b=%h expected 0 0 25 13",
                  alu_start, rsp_valid, alu_src1, alu_src2);
      end
      tick;                                 // cycle 4
      checks++;
      if ({rsp_valid, rsp_sel, rsp_result} !== {1'b1, 1'b0, e}) begin
         errors++;
         $display("FAIL add_rsp: got valid=%b sel=%b result=%h expected 1 0 %h",
                  rsp_valid, rsp_sel, rsp_result, e);
      end
      tick;
      exp_ops++;
      checks++;
      if ({rsp_valid, busy} !== 2'b00 || op_count !== 8'(exp_ops)) begin
         errors++;
         $display("FAIL add_done: got valid=%b busy=%b op_count=%0d expected 0 0 %0d",
                  rsp_valid, busy, op_count, exp_ops);
      end
   endtask

   task automatic test_wrap;
      bit ok, st;
      logic [8:0] e0, e1;
      rsp_ready = 1'b1;
      got_q.delete();
      e0 = {1'b1, ref_op(1'b1, 8'h05, 8'h07)};
      e1 = {1'b0, ref_op(1'b0, 8'hFF, 8'h01)};
      send(1'b1, 8'h05, 8'h07, ok, st);
      send(1'b0, 8'hFF, 8'h01, ok, st);
      cmd_valid = 1'b0;
      wait_rsp(2, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_rsp_count: got %0d responses expected 2", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== e0 || got_q[1] !== e1) begin
            errors++;
            $display("FAIL wrap_results: got %h %h expected %h %h", got_q[0], got_q[1], e0, e1);
         end
      end
      exp_ops += 2;
      checks++;
      if (op_count !== 8'(exp_ops)) begin
         errors++;
         $display("FAIL wrap_op_count: got %0d expected %0d", op_count, exp_ops);
      end
   endtask

   task automatic test_burst;
      bit ok, st, all_ok, saw_full;
      bit         s [6];
      logic [7:0] a [6];
      logic [7:0] b [6];
      int         bad;
      rsp_ready = 1'b1;
      got_q.delete();
      all_ok = 1'b1; saw_full = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s[i] = 1'($urandom);
         a[i] = 8'($urandom);
         b[i] = 8'($urandom);
         send(s[i], a[i], b[i], ok, st);
         all_ok &= ok;
         saw_full |= st;
      end
      cmd_valid = 1'b0;
      checks++;
      if (!all_ok || !saw_full) begin
         errors++;
         $display("FAIL burst_backpressure: accepted_all=%0b cmd_ready_dropped=%0b expected 1 1",
                  all_ok, saw_full);
      end
      wait_rsp(6, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL burst_rsp_count: got %0d responses expected 6", got_q.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 6; i++)
            if (got_q[i] !== {s[i], ref_op(s[i], a[i], b[i])}) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL burst_order: %0d of 6 results wrong, first got %h expected %h",
                     bad, got_q[0], {s[0], ref_op(s[0], a[0], b[0])});
         end
      end
      exp_ops += 6;
      checks++;
      if (op_count !== 8'(exp_ops)) begin
         errors++;
         $display("FAIL burst_op_count: got %0d expected %0d", op_count, exp_ops);
      end
   endtask

   task automatic test_backpressure;
      bit ok, st, stable;
      bit         s [2];
      logic [7:0] a [2];
      logic [7:0] b [2];
      logic [7:0] r;
      int         g, s0;
      rsp_ready = 1'b0;
      got_q.delete();
      for (int i = 0; i < 2; i++) begin
         s[i] = 1'($urandom); a[i] = 8'($urandom); b[i] = 8'($urandom);
         send(s[i], a[i], b[i], ok, st);
      end
      cmd_valid = 1'b0;
      g = 0;
      while (!rsp_valid && g < 50) begin tick; g++; end
      checks++;
      if (!rsp_valid || {rsp_sel, rsp_result} !== {s[0], ref_op(s[0], a[0], b[0])}) begin
         errors++;
         $display("FAIL bp_first_rsp: got valid=%b %h expected 1 %h", rsp_valid,
                  {rsp_sel, rsp_result}, {s[0], ref_op(s[0], a[0], b[0])});
      end
      r = rsp_result;
      s0 = start_cnt;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (!rsp_valid || rsp_result !== r) stable = 1'b0;
      end
      checks++;
      if (!stable || start_cnt != s0) begin
         errors++;
         $display("FAIL bp_hold: held=%0b new_starts=%0d expected 1 0", stable, start_cnt - s0);
      end
      rsp_ready = 1'b1;
      g = 0;
      while (start_cnt == s0 && g < 6) begin tick; g++; end
      checks++;
      if (start_cnt == s0) begin
         errors++;
         $display("FAIL bp_next_issue: got no alu_start within %0d cycles expected one", g);
      end
      wait_rsp(2, ok);
      checks++;
      if (!ok || got_q[1] !== {s[1], ref_op(s[1], a[1], b[1])}) begin
         errors++;
         $display("FAIL bp_second_rsp: got %0d rsps, last %h expected %h", got_q.size(),
                  ok ? got_q[1] : 9'h0, {s[1], ref_op(s[1], a[1], b[1])});
      end
      exp_ops += 2;
   endtask

   task automatic test_timeout;
      bit ok, st, saw_rsp;
      bit         s;
      logic [7:0] a, b;
      int         g, k;
      rsp_ready = 1'b1;
      got_q.delete();
      hang = 1'b1;
      send(1'($urandom), 8'($urandom), 8'($urandom), ok, st);
      cmd_valid = 1'b0;
      g = 0;
      while (!alu_start && g < 10) begin tick; g++; end
      // ISSUE cycle now; WAIT lasts TIMEOUT cycles, flag visible one cycle later.
      k = 0; saw_rsp = 1'b0;
      while (!err_timeout && k < 30) begin
         tick; k++;
         if (rsp_valid) saw_rsp = 1'b1;
      end
      checks++;
      if (k != TIMEOUT + 1 || !err_timeout || saw_rsp) begin
         errors++;
         $display("FAIL timeout_flag: got err after %0d cycles err=%b rsp_seen=%0b expected %0d 1 0",
                  k, err_timeout, saw_rsp, TIMEOUT + 1);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: got busy=%b expected 0", busy);
      end
      hang = 1'b0;
      s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      send(s, a, b, ok, st);
      cmd_valid = 1'b0;
      wait_rsp(1, ok);
      checks++;
      if (!ok || got_q.size() != 1 || got_q[0] !== {s, ref_op(s, a, b)} || err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_recover: got %0d rsps first %h err=%b expected 1 %h 1",
                  got_q.size(), ok ? got_q[0] : 9'h0, err_timeout, {s, ref_op(s, a, b)});
      end
      exp_ops += 1;
   endtask

   task automatic test_reset_mid;
      bit ok, st;
      int s0;
      rsp_ready = 1'b1;
      got_q.delete();
      hang = 1'b1;
      for (int i = 0; i < 4; i++) send(1'($urandom), 8'($urandom), 8'($urandom), ok, st);
      cmd_valid = 1'b0;
      tick;
      checks++;
      if (busy !== 1'b1 || alu_start !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_pre: got busy=%b start=%b expected 1 0", busy, alu_start);
      end
      #1 n_rst = 1'b0;
      #1;
      checks++;
      if ({busy, cmd_ready, rsp_valid, alu_start, err_timeout} !== 5'b01000 ||
          {op_count, alu_src1, alu_src2} !== 24'h0) begin
         errors++;
         $display("FAIL rstmid_async: got flags=%b regs=%h expected 01000 000000",
                  {busy, cmd_ready, rsp_valid, alu_start, err_timeout},
                  {op_count, alu_src1, alu_src2});
      end
      exp_ops = 0;
      hang = 1'b0;
      tick;
      n_rst = 1'b1;
      s0 = start_cnt;
      for (int i = 0; i < 20; i++) tick;
      checks++;
      if (start_cnt != s0 || got_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_discard: got starts=%0d rsps=%0d busy=%b expected 0 0 0",
                  start_cnt - s0, got_q.size(), busy);
      end
   endtask

   initial begin
      test_reset;
      test_single_add;
      test_wrap;
      test_burst;
      test_backpressure;
      test_timeout;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
